// File: rtl/aes_sub_bytes_engine.sv
// aes_sub_bytes_engine
// Multi-cycle AES SubBytes over a 128-bit state. LANES S-box lookups are
// done per cycle, so one block takes PASSES = 16/LANES substitution cycles.
// Optional feature macro: AES_INV_SBOX_EN. When defined, an inverse S-box
// ROM sits beside each forward ROM and in_inv (sampled with the block)
// selects InvSubBytes. When undefined, in_inv is ignored (port kept).
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Once valid is raised it stays high with
// stable data until that edge; ready never depends combinationally on valid.
module aes_sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int PASSES = 16 / LANES;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0] LAST_PASS = CW'(PASSES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte x lives at bit offset (255-x)*8, which is {~x, 3'b000}.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [10:0] base;
        base = {~x, 3'b000};
        return SBOX_FWD[base +: 8];
    endfunction

`ifdef AES_INV_SBOX_EN
    // FIPS-197 inverse S-box, same layout as the forward table.
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [10:0] base;
        base = {~x, 3'b000};
        return SBOX_INV[base +: 8];
    endfunction

    logic inv_q;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    logic [1:0]    state_q;
    logic [CW-1:0] pass_cnt;
    logic [127:0]  work_q;
    logic [127:0]  work_nxt;
    logic [7:0]    lane_out [LANES];

    // Lane l of pass k handles byte k*LANES + l of the work register.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] pos;
        logic [7:0] lane_in;
        assign pos     = 4'(int'(pass_cnt) * LANES + l);
        assign lane_in = work_q[{pos, 3'b000} +: 8];
`ifdef AES_INV_SBOX_EN
        assign lane_out[l] = inv_q ? inv_sbox(lane_in) : fwd_sbox(lane_in);
`else
        assign lane_out[l] = fwd_sbox(lane_in);
`endif
    end

    // Each byte takes its lane's result only during the pass that owns it.
    for (genvar b = 0; b < 16; b++) begin : g_byte
        localparam logic [CW-1:0] BYTE_PASS = CW'(b / LANES);
        assign work_nxt[8*b +: 8] = (pass_cnt == BYTE_PASS) ? lane_out[b % LANES]
                                                          : work_q[8*b +: 8];
    end

    // Control FSM, pass counter and work/mode registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            pass_cnt <= '0;
            work_q   <= '0;
`ifdef AES_INV_SBOX_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q   <= in_data;
                        pass_cnt <= '0;
`ifdef AES_INV_SBOX_EN
                        inv_q    <= in_inv;
`endif
                        state_q  <= SUB;
                    end
                end
                SUB: begin
                    work_q <= work_nxt;
                    if (pass_cnt == LAST_PASS) begin
                        pass_cnt <= '0;
                        state_q  <= DONE;
                    end else begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // No new block is taken here; IDLE follows the handshake.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SUB);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? work_q : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// tb_aes_sub_bytes_engine
// Five engines (LANES = 4, 1, 2, 8, 16) share data/mode/out_ready and each
// gets its own in_valid. The reference S-box is built from GF(2^8) inverse
// plus the affine map; a timeline model predicts ready/valid/busy per cycle.
// Follows AES_INV_SBOX_EN the same way as the design.
module tb_aes_sub_bytes_engine;

    localparam int NI = 5;

    function automatic int lanes_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    // Hand-computed accept-edge-to-valid latency per instance.
    function automatic int exp_lat(input int i);
        case (i)
            0:       return 5;
            1:       return 17;
            2:       return 9;
            3:       return 3;
            default: return 2;
        endcase
    endfunction

    logic         clk;
    logic         n_rst;
    logic         in_valid_v [NI];
    logic         in_ready_v [NI];
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid_v [NI];
    logic         out_ready;
    logic [127:0] out_data_v [NI];
    logic         busy_v [NI];
    logic [1:0]   dbg_v [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_sub_bytes_engine #(.LANES(lanes_of(g))) u_dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .in_inv    (in_inv),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_data  (out_data_v[g]),
            .busy      (busy_v[g]),
            .dbg_state (dbg_v[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference S-box ----------------
    logic [7:0] sb_fwd [256];
    logic [7:0] sb_inv [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] l, r;
        l = v << n;
        r = v >> (8 - n);
        return l | r;
    endfunction

    task automatic build_tables();
        logic [7:0] x, y, m;
        for (int xi = 0; xi < 256; xi++) begin
            x = 8'(xi);
            m = 8'h00;
            if (xi != 0) begin
                for (int yi = 1; yi < 256; yi++) begin
                    y = 8'(yi);
                    if (gmul(x, y) == 8'h01) m = y;
                end
            end
            sb_fwd[xi] = m ^ rotl8(m, 1) ^ rotl8(m, 2) ^ rotl8(m, 3) ^ rotl8(m, 4) ^ 8'h63;
        end
        for (int xi = 0; xi < 256; xi++) sb_inv[sb_fwd[xi]] = 8'(xi);
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? sb_inv[d[8*i +: 8]] : sb_fwd[d[8*i +: 8]];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Timeline model: a block accepted on the edge ending cycle c is busy
    // until c+PASSES, then valid until the out handshake; ready otherwise.
    longint       cyc = 0;
    bit           pend [NI];
    longint       due  [NI];
    logic [127:0] exp_data [NI];

    initial forever begin
        logic inv_eff;
        @(posedge clk or negedge n_rst);
        if (!n_rst) begin
            for (int i = 0; i < NI; i++) pend[i] = 1'b0;
            exp_q.delete();
        end else begin
`ifdef AES_INV_SBOX_EN
            inv_eff = in_inv;
`else
            inv_eff = 1'b0;
`endif
            for (int i = 0; i < NI; i++) begin
                if (pend[i]) begin
                    if (cyc >= due[i] && out_ready) pend[i] = 1'b0;
                end else if (in_valid_v[i]) begin
                    pend[i]     = 1'b1;
                    due[i]      = cyc + 1 + longint'(16 / lanes_of(i));
                    exp_data[i] = sub_bytes(in_data, inv_eff);
                    exp_q.push_back(exp_data[i]);
                end
            end
            cyc = cyc + 1;
        end
    end

    // Per-cycle compare of every instance against the model.
    initial forever begin
        bit ev;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            ev = pend[i] && (cyc >= due[i]);
            chk($sformatf("in_ready[%0d]", i), 128'(in_ready_v[i]), 128'(!pend[i]));
            chk($sformatf("out_valid[%0d]", i), 128'(out_valid_v[i]), 128'(ev));
            chk($sformatf("busy[%0d]", i), 128'(busy_v[i]), 128'(pend[i] && !ev));
            if (ev) chk($sformatf("out_data[%0d]", i), out_data_v[i], exp_data[i]);
            if (out_valid_v[i] && out_ready && n_rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake[%0d] act=%h exp=none", i, out_data_v[i]);
                end else begin
                    chk($sformatf("handshake[%0d]", i), out_data_v[i], exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block, wait for acceptance, then count edges until out_valid.
    // Returns at the negedge where out_valid is seen (or the budget ran out).
    task automatic send_block(input int i, input logic [127:0] d, input logic inv,
                              input bit noise, output int lat);
        int w;
        in_data = d;
        in_inv  = inv;
        in_valid_v[i] = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready_v[i] && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready_v[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[%0d] act=in_ready_low exp=in_ready_high", i);
        end
        tick();
        in_valid_v[i] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid_v[i] && lat < 40) begin
            if (noise) begin
                in_data = {$urandom, $urandom, $urandom, $urandom};
                in_inv  = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
            @(negedge clk);
        end
    endtask

    // ---------------- directed stimulus ----------------
    localparam logic [127:0] V_PT  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] V_SB  = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;
    localparam logic [127:0] V_SB2 = 128'hfb13dc2e_afb0c3e6_1c289187_b3783447;

    initial begin
        int lat;
        n_rst     = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NI; i++) in_valid_v[i] = 1'b0;
        build_tables();

        // Pin the reference model to known values.
        chk("model_zero", sub_bytes(128'h0, 1'b0), {16{8'h63}});
        chk("model_fwd", sub_bytes(V_PT, 1'b0), V_SB);
        chk("model_inv", sub_bytes(V_SB, 1'b1), V_PT);

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), 128'(in_ready_v[i]), 128'(1));
            chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid_v[i]), 128'(0));
            chk($sformatf("rst_out_data[%0d]", i), out_data_v[i], 128'h0);
            chk($sformatf("rst_busy[%0d]", i), 128'(busy_v[i]), 128'(0));
        end
        tick();
        n_rst = 1'b1;
        tick();

        // Zero block on LANES=4.
        send_block(0, 128'h0, 1'b0, 1'b0, lat);
        chk("t1_latency", 128'(lat), 128'(exp_lat(0)));
        chk("t1_data", out_data_v[0], {16{8'h63}});
        tick();

        // FIPS vector on every lane count, with latency.
        for (int i = 0; i < NI; i++) begin
            send_block(i, V_PT, 1'b0, 1'b0, lat);
            chk($sformatf("t2_latency[%0d]", i), 128'(lat), 128'(exp_lat(i)));
            chk($sformatf("t2_data[%0d]", i), out_data_v[i], V_SB);
            tick();
            @(negedge clk);
            chk($sformatf("t2_ready_after[%0d]", i), 128'(in_ready_v[i]), 128'(1));
            tick();
        end

        // Back-pressure in DONE: data stable, second block refused.
        out_ready = 1'b0;
        send_block(0, V_PT, 1'b0, 1'b0, lat);
        chk("t3_latency", 128'(lat), 128'(exp_lat(0)));
        for (int k = 0; k < 10; k++) begin
            tick();
            in_valid_v[0] = 1'b1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("t3_hold_data", out_data_v[0], V_SB);
            chk("t3_hold_ready", 128'(in_ready_v[0]), 128'(0));
        end
        tick();
        in_valid_v[0] = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t3_ready_after", 128'(in_ready_v[0]), 128'(1));
        chk("t3_valid_after", 128'(out_valid_v[0]), 128'(0));
        tick();

        // Reset during pass 2 of SUB.
        in_data = V_PT;
        in_valid_v[0] = 1'b1;
        tick();
        in_valid_v[0] = 1'b0;
        tick();
        tick();
        chk("t4_busy_before", 128'(busy_v[0]), 128'(1));
        n_rst = 1'b0;
        #1;
        chk("t4_rst_ready", 128'(in_ready_v[0]), 128'(1));
        chk("t4_rst_valid", 128'(out_valid_v[0]), 128'(0));
        chk("t4_rst_busy", 128'(busy_v[0]), 128'(0));
        chk("t4_rst_data", out_data_v[0], 128'h0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        send_block(0, {16{8'h53}}, 1'b0, 1'b0, lat);
        chk("t4_latency", 128'(lat), 128'(exp_lat(0)));
        chk("t4_data", out_data_v[0], {16{8'hed}});
        tick();

        // Inverse request.
        send_block(0, V_SB, 1'b1, 1'b0, lat);
`ifdef AES_INV_SBOX_EN
        chk("t5_data", out_data_v[0], V_PT);
`else
        chk("t5_data", out_data_v[0], V_SB2);
`endif
        tick();

        // Input noise while the block is in flight.
        send_block(0, V_PT, 1'b0, 1'b1, lat);
        chk("t6_latency", 128'(lat), 128'(exp_lat(0)));
        chk("t6_data", out_data_v[0], V_SB);
        in_inv = 1'b0;
        tick();
        tick();

        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_engine.md
Name: aes_sub_bytes_engine

Overview:
Parametrised, multi-cycle AES SubBytes unit that applies the S-box byte-wise to a 128-bit state using LANES S-box instances per cycle. Valid/ready handshakes on input and output let it drop into the round datapath between AddRoundKey and ShiftRows. It trades area against latency and can optionally perform InvSubBytes for the decrypt path.

Parameters:
LANES, 4, number of S-box lookups performed per cycle; legal values 1, 2, 4, 8, 16; must divide 16.
PASSES, 16/LANES (derived localparam, not overridable), number of substitution cycles per block.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents a block
in_ready  output  1  engine can accept a block
in_data  input  128  state to substitute; byte i = in_data[8i+7:8i]
in_inv  input  1  1 = inverse S-box for this block, 0 = forward; sampled with the block
out_valid  output  1  substituted block available
out_ready  input  1  downstream accepts the block
out_data  output  128  substituted state, same byte ordering
busy  output  1  high while in SUB state

Behaviour:
- Clocking: everything on posedge clk. n_rst low clears all state asynchronously, independent of clk.
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, pass counter=0, FSM=IDLE.
- FSM states: IDLE, SUB, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, capture in_data into the work register, latch in_inv into mode register, clear counter, go to SUB.
- SUB: in_ready=0, busy=1. In pass k (counter=k), bytes k*LANES .. k*LANES+LANES-1 of the work register are replaced by their S-box (or inverse S-box) values. Counter increments each cycle. After pass PASSES-1, go to DONE.
- DONE: out_valid=1, out_data=work register. Hold out_data stable while out_valid&&!out_ready. On out_valid&&out_ready go to IDLE and deassert out_valid next cycle.
- Lookup: high nibble selects the row, low nibble selects the column (FIPS-197 table). The table is a constant ROM.
- Latency: accept edge to out_valid high is PASSES+1 cycles (LANES=4 gives 5; LANES=16 gives 2). Throughput is one block per PASSES+2 cycles with out_ready tied high.
- No back-to-back acceptance: a new block is not accepted in DONE, even if out_ready is high in the same cycle. in_ready rises the cycle after the handshake.
- Reset mid-SUB or mid-DONE: the block is discarded and the outputs return to their reset values. No partial output is ever flagged valid.
- in_data and in_inv are ignored in every state except IDLE. in_inv changes during SUB do not affect the block in flight.
- Counter width: $clog2(PASSES) bits, minimum 1. For LANES=16 the SUB state lasts exactly one cycle.

Optional Feature:
Macro AES_INV_SBOX_EN.
- Defined: the inverse S-box ROM is instantiated per lane, and in_inv selects forward or inverse per block.
- Undefined: there is no inverse ROM, in_inv is ignored, and every block uses the forward S-box. The port remains present so the interface is unchanged.

Test Plan:
1. Reset with LANES=4 → in_ready=1, out_valid=0, out_data=0. Send in_data=128'h0, in_inv=0 → after 5 cycles out_valid=1, out_data=128'h63636363_63636363_63636363_63636363.
2. in_data=128'h00112233_44556677_8899aabb_ccddeeff, forward → out_data=128'h638293c3_1bfc33f5_c4eeacea_4bc12816. Repeat for LANES=1, 2, 8 and 16 and check latency is 17, 9, 3 and 2 cycles respectively.
3. Hold out_ready=0 for 10 cycles in DONE → out_data stays stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready → handshake completes, and in_ready=1 on the next cycle.
4. Assert n_rst low during pass 2 of SUB → outputs go to reset values immediately. After release, a fresh block of 128'h53 replicated yields 128'hED replicated.
5. With AES_INV_SBOX_EN defined: in_data=128'h638293c3_1bfc33f5_c4eeacea_4bc12816, in_inv=1 → out_data=128'h00112233_44556677_8899aabb_ccddeeff. With the macro undefined, the same stimulus gives the forward substitution of that value.
6. Toggle in_inv and in_data every cycle during SUB → the result matches only the values captured at acceptance.
